// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fir_ctrl_pkg: shared sequencer state encoding, FIR default sizes, width rules.
// Rev 1.0
// ----------------------------------------------------------------------------
package fir_ctrl_pkg;

  localparam int FIR_X_N_SIZE    = 8;
  localparam int FIR_TAP_SIZE    = 2;
  localparam int FIR_NBR_OF_TAPS = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_STREAM     = 3'd1,
    ST_PRE_GUARD  = 3'd2,
    ST_LOAD       = 3'd3,
    ST_POST_GUARD = 3'd4
  } seq_state_e;

  // Number of copies of the coefficient sign bit needed to fill x_n.
  function automatic int sext_pad_bits(input int xn_w, input int tap_w);
    return (xn_w > tap_w) ? (xn_w - tap_w) : 0;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_coef_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fir_coef_sequencer_if: sample stream, coefficient port and FIR-side strobes.
// Rev 1.0
// ----------------------------------------------------------------------------
interface fir_coef_sequencer_if
  import fir_ctrl_pkg::*;
#(
  parameter int X_N_SIZE = FIR_X_N_SIZE,
  parameter int TAP_SIZE = FIR_TAP_SIZE
);
  logic signed [X_N_SIZE-1:0] s_sample;
  logic                       s_sample_valid;
  logic                       s_sample_ready;
  logic signed [TAP_SIZE-1:0] cfg_coef;
  logic                       cfg_valid;
  logic                       cfg_last;
  logic                       cfg_ready;
  logic        [X_N_SIZE-1:0] fir_x_n;
  logic                       fir_tvalid;
  logic                       fir_set_coeffs;
  logic                       busy;
  logic                       err_cfg;

  modport master (
    output s_sample, s_sample_valid, cfg_coef, cfg_valid, cfg_last,
    input  s_sample_ready, cfg_ready, fir_x_n, fir_tvalid, fir_set_coeffs, busy, err_cfg
  );

  modport slave (
    input  s_sample, s_sample_valid, cfg_coef, cfg_valid, cfg_last,
    output s_sample_ready, cfg_ready, fir_x_n, fir_tvalid, fir_set_coeffs, busy, err_cfg
  );
endinterface
`default_nettype wire

// File: rtl/fir_coef_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fir_coef_stage: collects one coefficient set, checks framing, flags pending.
// Optional FIR_COEF_SEQ_STATS_EN adds a saturating framing-error counter. Rev 1.0
// ----------------------------------------------------------------------------
module fir_coef_stage
  import fir_ctrl_pkg::*;
#(
  parameter int TAP_SIZE    = FIR_TAP_SIZE,
  parameter int NBR_OF_TAPS = FIR_NBR_OF_TAPS,
  parameter int IDX_W       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [TAP_SIZE-1:0] cfg_coef_i,
  input  logic                cfg_valid_i,
  input  logic                cfg_last_i,
  input  logic                load_done_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic [TAP_SIZE-1:0] rd_data_o,
  output logic                cfg_ready_o,
  output logic                pending_o,
  output logic                pending_next_o,
  output logic                err_cfg_o
`ifdef FIR_COEF_SEQ_STATS_EN
  ,
  output logic [7:0]          drop_count_o
`endif
);

  logic [TAP_SIZE-1:0] stage_q [NBR_OF_TAPS];
  logic [TAP_SIZE-1:0] stage_d [NBR_OF_TAPS];
  logic [IDX_W-1:0]    beat_q, beat_d;
  logic                pending_q, pending_d;
  logic                err_q, err_d;
  logic                w_accept;
  logic                w_at_end;
  logic                w_frame_err;

  assign w_accept    = cfg_valid_i && !pending_q;
  assign w_at_end    = (beat_q == IDX_W'(NBR_OF_TAPS - 1));
  // cfg_last must coincide exactly with the final beat position.
  assign w_frame_err = w_accept && (cfg_last_i != w_at_end);

  always_comb begin
    stage_d   = stage_q;
    beat_d    = beat_q;
    pending_d = pending_q;
    err_d     = err_q;
    if (load_done_i) begin
      pending_d = 1'b0;
    end
    if (w_frame_err) begin
      err_d  = 1'b1;
      beat_d = '0;
    end else if (w_accept) begin
      stage_d[beat_q] = cfg_coef_i;
      if (w_at_end) begin
        beat_d    = '0;
        pending_d = 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q   <= '{default: '0};
      beat_q    <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      beat_q    <= beat_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign rd_data_o      = stage_q[rd_idx_i];
  assign cfg_ready_o    = !pending_q;
  assign pending_o      = pending_q;
  assign pending_next_o = pending_d;
  assign err_cfg_o      = err_q;

`ifdef FIR_COEF_SEQ_STATS_EN
  logic [7:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (w_frame_err && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_q <= 8'd0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count_o = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: rtl/fir_coef_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fir_coef_sequencer: shares FIR x_n/tvalid/set_coeffs between samples and loads.
// Optional FIR_COEF_SEQ_STATS_EN adds load_count/drop_count outputs. Rev 1.0
// ----------------------------------------------------------------------------
module fir_coef_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int X_N_SIZE     = FIR_X_N_SIZE,
  parameter int TAP_SIZE     = FIR_TAP_SIZE,
  parameter int NBR_OF_TAPS  = FIR_NBR_OF_TAPS,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  fir_coef_sequencer_if.slave bus
`ifdef FIR_COEF_SEQ_STATS_EN
  ,
  output logic [7:0]          load_count,
  output logic [7:0]          drop_count
`endif
);

  localparam int IDX_W   = idx_width(NBR_OF_TAPS);
  localparam int CNT_MAX = (GUARD_CYCLES > NBR_OF_TAPS) ? GUARD_CYCLES : NBR_OF_TAPS;
  localparam int CNT_W   = idx_width(CNT_MAX);
  localparam int PAD_W   = sext_pad_bits(X_N_SIZE, TAP_SIZE);

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [X_N_SIZE-1:0] fir_x_n_q, fir_x_n_d;
  logic                fir_tvalid_q, fir_tvalid_d;
  logic                fir_set_q, fir_set_d;
  logic                s_ready_q, s_ready_d;
  logic                w_sample_acc;
  logic                w_load_done;
  logic                w_pending;
  logic                w_pending_next;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [TAP_SIZE-1:0] w_rd_data;
  logic [X_N_SIZE-1:0] w_coef_sext;

  fir_coef_stage #(
    .TAP_SIZE    (TAP_SIZE),
    .NBR_OF_TAPS (NBR_OF_TAPS),
    .IDX_W       (IDX_W)
  ) u_stage (
    .clk            (clk),
    .reset          (reset),
    .cfg_coef_i     (bus.cfg_coef),
    .cfg_valid_i    (bus.cfg_valid),
    .cfg_last_i     (bus.cfg_last),
    .load_done_i    (w_load_done),
    .rd_idx_i       (w_rd_idx),
    .rd_data_o      (w_rd_data),
    .cfg_ready_o    (bus.cfg_ready),
    .pending_o      (w_pending),
    .pending_next_o (w_pending_next),
    .err_cfg_o      (bus.err_cfg)
`ifdef FIR_COEF_SEQ_STATS_EN
    ,
    .drop_count_o   (drop_count)
`endif
  );

  assign w_sample_acc = bus.s_sample_valid && s_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_load_done = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_STREAM: begin
        cnt_d = '0;
        if (w_pending) begin
          state_d = ST_PRE_GUARD;
        end else if (w_sample_acc) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE_GUARD: begin
        if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        if (cnt_q == CNT_W'(NBR_OF_TAPS - 1)) begin
          state_d     = ST_POST_GUARD;
          cnt_d       = '0;
          w_load_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_POST_GUARD: begin
        if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Highest stage entry goes out first so stage[0] ends up in tap 0.
  assign w_rd_idx = (state_d == ST_LOAD) ? IDX_W'(NBR_OF_TAPS - 1 - int'(cnt_d)) : '0;

  generate
    if (PAD_W > 0) begin : g_sext
      assign w_coef_sext = {{PAD_W{w_rd_data[TAP_SIZE-1]}}, w_rd_data};
    end else begin : g_trunc
      assign w_coef_sext = w_rd_data[X_N_SIZE-1:0];
    end
  endgenerate

  always_comb begin
    fir_tvalid_d = w_sample_acc;
    fir_set_d    = (state_d == ST_LOAD);
    fir_x_n_d    = '0;
    if (w_sample_acc) begin
      fir_x_n_d = bus.s_sample;
    end else if (fir_set_d) begin
      fir_x_n_d = w_coef_sext;
    end
    s_ready_d = ((state_d == ST_IDLE) || (state_d == ST_STREAM)) && !w_pending_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      fir_x_n_q    <= '0;
      fir_tvalid_q <= 1'b0;
      fir_set_q    <= 1'b0;
      s_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fir_x_n_q    <= fir_x_n_d;
      fir_tvalid_q <= fir_tvalid_d;
      fir_set_q    <= fir_set_d;
      s_ready_q    <= s_ready_d;
    end
  end

  assign bus.fir_x_n        = fir_x_n_q;
  assign bus.fir_tvalid     = fir_tvalid_q;
  assign bus.fir_set_coeffs = fir_set_q;
  assign bus.s_sample_ready = s_ready_q;
  assign bus.busy           = (state_q == ST_PRE_GUARD) || (state_q == ST_LOAD) ||
                              (state_q == ST_POST_GUARD);

`ifdef FIR_COEF_SEQ_STATS_EN
  logic [7:0] load_count_q, load_count_d;

  assign load_count_d = w_load_done ? (load_count_q + 8'd1) : load_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      load_count_q <= 8'd0;
    end else begin
      load_count_q <= load_count_d;
    end
  end

  assign load_count = load_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_coef_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fir_coef_sequencer: directed vectors for sample forwarding and coefficient loads.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fir_coef_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fir_coef_sequencer_if bus ();

`ifdef FIR_COEF_SEQ_STATS_EN
  logic [7:0] load_count;
  logic [7:0] drop_count;
`endif

  fir_coef_sequencer #(
    .X_N_SIZE     (8),
    .TAP_SIZE     (2),
    .NBR_OF_TAPS  (3),
    .GUARD_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FIR_COEF_SEQ_STATS_EN
    ,
    .load_count (load_count),
    .drop_count (drop_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  logic [7:0] xn_a   [0:15];
  bit         busy_a [0:15];
  bit         set_a  [0:15];
  bit         sr_a   [0:15];
  bit         cr_a   [0:15];
  bit         tv_a   [0:15];
  int         busy_n, set_n, sr_low_n, tv_early_n;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic observe(input int n);
    busy_n = 0; set_n = 0; sr_low_n = 0; tv_early_n = 0;
    for (int c = 1; c <= n; c++) begin
      step();
      xn_a[c]   = bus.fir_x_n;
      busy_a[c] = bus.busy;
      set_a[c]  = bus.fir_set_coeffs;
      sr_a[c]   = bus.s_sample_ready;
      cr_a[c]   = bus.cfg_ready;
      tv_a[c]   = bus.fir_tvalid;
      if (bus.busy) busy_n++;
      if (bus.fir_set_coeffs) set_n++;
      if (!bus.s_sample_ready) sr_low_n++;
      if (bus.fir_tvalid && c <= 8) tv_early_n++;
    end
  endtask

  task automatic send_beat(input logic [1:0] coef, input logic last);
    bus.cfg_valid = 1'b1;
    bus.cfg_coef  = coef;
    bus.cfg_last  = last;
    step();
    bus.cfg_valid = 1'b0;
    bus.cfg_last  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) check_val("strobe_excl", bus.fir_tvalid & bus.fir_set_coeffs, 32'd0);
  end

  initial begin
    bus.s_sample = '0; bus.s_sample_valid = 1'b0;
    bus.cfg_coef = '0; bus.cfg_valid = 1'b0; bus.cfg_last = 1'b0;
    reset = 1'b1;
    step(); step();
    check_val("rst_x_n", bus.fir_x_n, 32'h00);
    check_val("rst_tvalid", bus.fir_tvalid, 32'd0);
    check_val("rst_set", bus.fir_set_coeffs, 32'd0);
    check_val("rst_busy", bus.busy, 32'd0);
    check_val("rst_err", bus.err_cfg, 32'd0);
    check_val("rst_s_ready", bus.s_sample_ready, 32'd0);
    check_val("rst_cfg_ready", bus.cfg_ready, 32'd1);
    reset = 1'b0;
    mon_en = 1'b1;
    step();
    check_val("s_ready_up", bus.s_sample_ready, 32'd1);

    // Back-to-back samples, one cycle latency.
    bus.s_sample_valid = 1'b1; bus.s_sample = 8'h05; step();
    check_val("smp0_x_n", bus.fir_x_n, 32'h05); check_val("smp0_tv", bus.fir_tvalid, 32'd1);
    bus.s_sample = 8'h7F; step();
    check_val("smp1_x_n", bus.fir_x_n, 32'h7F); check_val("smp1_tv", bus.fir_tvalid, 32'd1);
    bus.s_sample = 8'h80; step();
    check_val("smp2_x_n", bus.fir_x_n, 32'h80); check_val("smp2_tv", bus.fir_tvalid, 32'd1);
    bus.s_sample_valid = 1'b0; step();
    check_val("smp_end_tv", bus.fir_tvalid, 32'd0);

    // Set 01,11,10 loads as FE,FF,01.
    send_beat(2'b01, 1'b0); send_beat(2'b11, 1'b0); send_beat(2'b10, 1'b1);
    check_val("ld_cfg_ready_lo", bus.cfg_ready, 32'd0);
    check_val("ld_s_ready_lo", bus.s_sample_ready, 32'd0);
    observe(10);
    check_val("ld_set_n", set_n, 32'd3);
    check_val("ld_busy_n", busy_n, 32'd7);
    check_val("ld_pre_guard", set_a[2], 32'd0);
    check_val("ld_set_first", set_a[3], 32'd1);
    check_val("ld_xn0", xn_a[3], 32'hFE);
    check_val("ld_xn1", xn_a[4], 32'hFF);
    check_val("ld_xn2", xn_a[5], 32'h01);
    check_val("ld_cfg_ready_last", cr_a[5], 32'd0);
    check_val("ld_cfg_ready_back", cr_a[6], 32'd1);
    check_val("ld_s_ready_lo7", sr_a[7], 32'd0);
    check_val("ld_s_ready_back", sr_a[8], 32'd1);

    // Early cfg_last is a framing error with no load.
    send_beat(2'b01, 1'b0); send_beat(2'b11, 1'b1);
    check_val("fe_err", bus.err_cfg, 32'd1);
    check_val("fe_cfg_ready", bus.cfg_ready, 32'd1);
    observe(8);
    check_val("fe_set_n", set_n, 32'd0);
    check_val("fe_busy_n", busy_n, 32'd0);
    send_beat(2'b01, 1'b0); send_beat(2'b01, 1'b0); send_beat(2'b01, 1'b0);
    observe(8);
    check_val("nolast_set_n", set_n, 32'd0);
    send_beat(2'b10, 1'b0); send_beat(2'b01, 1'b0); send_beat(2'b11, 1'b1);
    observe(10);
    check_val("fe2_set_n", set_n, 32'd3);
    check_val("fe2_xn0", xn_a[3], 32'hFF);
    check_val("fe2_xn1", xn_a[4], 32'h01);
    check_val("fe2_xn2", xn_a[5], 32'hFE);
    check_val("fe2_err_sticky", bus.err_cfg, 32'd1);

    // Continuous samples while a set completes.
    bus.s_sample_valid = 1'b1; bus.s_sample = 8'h11; step();
    bus.cfg_valid = 1'b1; bus.cfg_coef = 2'b01; bus.cfg_last = 1'b0;
    bus.s_sample = 8'h12; step();
    bus.s_sample = 8'h13; step();
    bus.s_sample = 8'h14; bus.cfg_last = 1'b1; step();
    bus.cfg_valid = 1'b0; bus.cfg_last = 1'b0;
    check_val("st_fwd_x_n", bus.fir_x_n, 32'h14);
    check_val("st_fwd_tv", bus.fir_tvalid, 32'd1);
    check_val("st_s_ready_lo", bus.s_sample_ready, 32'd0);
    bus.s_sample = 8'h15;
    observe(12);
    check_val("st_stall_rest", sr_low_n, 32'd7);
    check_val("st_tv_in_stall", tv_early_n, 32'd0);
    check_val("st_set_n", set_n, 32'd3);
    check_val("st_xn0", xn_a[3], 32'h01);
    check_val("st_resume_tv", tv_a[9], 32'd1);
    check_val("st_resume_x_n", xn_a[9], 32'h15);
    bus.s_sample_valid = 1'b0; step();

    // Reset during the second LOAD cycle.
    send_beat(2'b01, 1'b0); send_beat(2'b11, 1'b0); send_beat(2'b10, 1'b1);
    step(); step(); step(); step();
    check_val("rl_in_load", bus.fir_set_coeffs, 32'd1);
    check_val("rl_in_load_xn", bus.fir_x_n, 32'hFF);
    reset = 1'b1; step();
    check_val("rl_x_n", bus.fir_x_n, 32'h00);
    check_val("rl_set", bus.fir_set_coeffs, 32'd0);
    check_val("rl_tvalid", bus.fir_tvalid, 32'd0);
    check_val("rl_busy", bus.busy, 32'd0);
    check_val("rl_err", bus.err_cfg, 32'd0);
    check_val("rl_s_ready", bus.s_sample_ready, 32'd0);
    check_val("rl_cfg_ready", bus.cfg_ready, 32'd1);
    reset = 1'b0;
    observe(8);
    check_val("rl_no_set", set_n, 32'd0);
    check_val("rl_no_busy", busy_n, 32'd0);
    check_val("rl_s_ready_up", sr_a[1], 32'd1);

`ifdef FIR_COEF_SEQ_STATS_EN
    check_val("stat_load_rst", load_count, 32'd0);
    check_val("stat_drop_rst", drop_count, 32'd0);
    send_beat(2'b01, 1'b0); send_beat(2'b01, 1'b0); send_beat(2'b01, 1'b1);
    observe(10);
    send_beat(2'b11, 1'b1);
    step();
    send_beat(2'b10, 1'b0); send_beat(2'b10, 1'b0); send_beat(2'b10, 1'b1);
    observe(10);
    check_val("stat_load", load_count, 32'd2);
    check_val("stat_drop", drop_count, 32'd1);
`endif

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
